// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready in and out.
// Optional early termination when the remaining multiplier digits are all zero: define MULT_EARLY_TERM_EN.
module booth_mult_seq #(
  parameter int WIDTH            = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int BW   = WIDTH + 3;
  localparam int NDIG = WIDTH / 2 + 1;
  localparam int K    = (NDIG + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
  localparam int CW   = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [BW-1:0]    mplr_q, mplr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             last_step;

  function automatic logic [PW-1:0] booth_pp(input logic [2:0] sel, input logic [PW-1:0] m);
    case (sel)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m << 1;
      3'b100:         booth_pp = -(m << 1);
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = '0;
    endcase
  endfunction

  // Multiplier register holds {ext_b, b[-1]} and shifts arithmetically, so bits [2:0]
  // are always the current digit and digits past the top recode to zero.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
          mplr_d  = {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
          acc_d = acc_d + booth_pp(mplr_q[2*j +: 3], mcand_q << (2 * j));
        end
        mcand_d   = mcand_q << (2 * DIGITS_PER_CYCLE);
        mplr_d    = BW'($signed(mplr_q) >>> (2 * DIGITS_PER_CYCLE));
        cnt_d     = cnt_q + 1'b1;
        last_step = (cnt_q == CW'(K - 1));
`ifdef MULT_EARLY_TERM_EN
        if ((&mplr_d) || (~|mplr_d)) last_step = 1'b1;
`endif
        if (last_step) begin
          state_d = DONE;
          hi_d    = acc_d[PW-1:WIDTH];
          lo_d    = acc_d[WIDTH-1:0];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - bench for booth_mult_seq: 32-bit directed vectors plus an 8-bit, 2-digit sweep.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        iv32 = 1'b0, sg32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, ov32, bz32;
  logic [31:0] hi32, lo32;
  logic        iv8 = 1'b0, sg8 = 1'b0, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, bz8;
  logic [7:0]  hi8, lo8;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp32 = '0;
  logic [15:0] exp8  = '0;

  booth_mult_seq #(.WIDTH(32), .DIGITS_PER_CYCLE(1)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .is_signed(sg32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .hi(hi32), .lo(lo32), .busy(bz32));

  booth_mult_seq #(.WIDTH(8), .DIGITS_PER_CYCLE(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .is_signed(sg8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .hi(hi8), .lo(lo8), .busy(bz8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Operand as a plain integer after WIDTH+2-bit extension.
  function automatic longint ext(input bit sgn, input logic [31:0] v, input int w);
    longint x;
    x = longint'(v) & ((longint'(1) << w) - 1);
    if (sgn && x[w-1]) x = x - (longint'(1) << w);
    return x;
  endfunction

  function automatic logic [63:0] ref_prod(input bit sgn, input logic [31:0] av, input logic [31:0] bv,
                                           input int w);
    longint m;
    m = ext(sgn, av, w) * ext(sgn, bv, w);
    if (w < 32) m = m & ((longint'(1) << (2 * w)) - 1);
    return m;
  endfunction

  function automatic int ref_lat(input bit sgn, input logic [31:0] bv, input int w, input int d);
    int k;
`ifdef MULT_EARLY_TERM_EN
    longint y;
`endif
    k = (w / 2 + 1 + d - 1) / d;
`ifdef MULT_EARLY_TERM_EN
    y = ext(sgn, bv, w);
    for (int i = 1; i < k; i++) begin
      if ((y >>> (2 * i * d - 1)) == 0 || (y >>> (2 * i * d - 1)) == -1) return i;
    end
`endif
    return k;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov32) begin
        check("mon_hi32", hi32, exp32[63:32]);
        check("mon_lo32", lo32, exp32[31:0]);
        check("mon_in_ready32_done", ir32, 1'b0);
        check("mon_busy32_done", bz32, 1'b1);
      end
      if (ov8) begin
        check("mon_prod8", {hi8, lo8}, exp8);
        check("mon_in_ready8_done", ir8, 1'b0);
      end
    end
  end

  task automatic do_op(input bit w8, input bit sgn, input logic [31:0] av, input logic [31:0] bv,
                       input int hold, output logic [63:0] prod, output int lat);
    int          guard;
    logic [63:0] m;
    @(negedge clk);
    guard = 0;
    while (!(w8 ? ir8 : ir32) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("in_ready_timeout", 0, 1);
    m = ref_prod(sgn, av, bv, w8 ? 8 : 32);
    if (w8) begin
      sg8 = sgn; a8 = av[7:0]; b8 = bv[7:0]; iv8 = 1'b1; exp8 = m[15:0];
    end else begin
      sg32 = sgn; a32 = av; b32 = bv; iv32 = 1'b1; exp32 = m;
    end
    @(posedge clk);
    #1 iv8 = 1'b0; iv32 = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (w8 ? ov8 : ov32) break;
    end
    if (lat >= 40) check("out_valid_timeout", 0, 1);
    prod = w8 ? {48'd0, hi8, lo8} : {hi32, lo32};
    for (int h = 0; h < hold; h++) begin
      if (w8) begin a8 = ~av[7:0]; b8 = bv[7:0] + 8'd1; iv8 = 1'b1; end
      else begin a32 = ~av; b32 = bv + 32'd1; iv32 = 1'b1; end
      @(posedge clk);
      @(negedge clk);
      check("hold_in_ready", w8 ? ir8 : ir32, 1'b0);
      check("hold_out_valid", w8 ? ov8 : ov32, 1'b1);
      check("hold_prod_stable", w8 ? {48'd0, hi8, lo8} : {hi32, lo32}, prod);
    end
    iv8 = 1'b0; iv32 = 1'b0;
    if (w8) or8 = 1'b1; else or32 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0; or32 = 1'b0;
    @(negedge clk);
    check("handoff_out_valid", w8 ? ov8 : ov32, 1'b0);
    check("handoff_in_ready", w8 ? ir8 : ir32, 1'b1);
  endtask

  task automatic t32(input string name, input bit sgn, input logic [31:0] av, input logic [31:0] bv,
                     input logic [63:0] lit, input int hold);
    logic [63:0] p;
    int          l;
    do_op(1'b0, sgn, av, bv, hold, p, l);
    check({name, "_prod"}, p, lit);
    check({name, "_model"}, ref_prod(sgn, av, bv, 32), lit);
    check({name, "_lat"}, l, ref_lat(sgn, bv, 32, 1));
  endtask

  task automatic t8(input bit sgn, input logic [7:0] av, input logic [7:0] bv);
    logic [63:0] p;
    int          l;
    do_op(1'b1, sgn, {24'd0, av}, {24'd0, bv}, 0, p, l);
    check("sweep8_prod", p, ref_prod(sgn, {24'd0, av}, {24'd0, bv}, 8));
    check("sweep8_lat", l, ref_lat(sgn, {24'd0, bv}, 8, 2));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] p;
    int          l;
    logic [7:0]  blist [10];
    blist = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h55, 8'h7f, 8'h80, 8'h81, 8'hfe, 8'hff};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready32", ir32, 1'b0);
    check("rst_in_ready8", ir8, 1'b0);
    check("rst_out_valid", ov32, 1'b0);
    check("rst_busy", bz32, 1'b0);
    check("rst_hilo", {hi32, lo32}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", ir32, 1'b1);
    check("post_rst_out_valid", ov32, 1'b0);

    do_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, p, l);
    check("t1_prod", p, 64'h0000_0000_0000_0001);
`ifndef MULT_EARLY_TERM_EN
    check("t1_lat17", l, 17);
`endif
    t32("t2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    t32("t3u", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    t32("t3s", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0);
    do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 0, p, l);
    check("t4_prod", p, 64'hFFFF_FFFF_FFFF_FFEB);
`ifdef MULT_EARLY_TERM_EN
    check("t4_lat", l, 2);
`else
    check("t4_lat", l, 17);
`endif
    t32("minneg", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000, 0);
    t32("umsb", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    t32("maxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0);
    t32("zero", 1'b1, 32'h0, 32'h1234_5678, 64'h0, 0);

    t32("t5_bp", 1'b0, 32'hDEAD_BEEF, 32'd2, 64'h0000_0001_BD5B_7DDE, 5);
    t32("t5_next", 1'b1, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 0);

    @(negedge clk);
    sg32 = 1'b1; a32 = 32'd12345; b32 = 32'd678; iv32 = 1'b1;
    @(posedge clk);
    #1 iv32 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_out_valid", ov32, 1'b0);
    check("t6_hilo", {hi32, lo32}, 64'd0);
    check("t6_in_ready", ir32, 1'b1);
    check("t6_busy", bz32, 1'b0);
    t32("t6_after", 1'b1, 32'd3, 32'd5, 64'd15, 0);

    check("pin8_s80", ref_prod(1'b1, 32'h80, 32'h80, 8), 64'h4000);
    check("pin8_uff", ref_prod(1'b0, 32'hFF, 32'hFF, 8), 64'hFE01);
    check("pin8_sff", ref_prod(1'b1, 32'hFF, 32'hFF, 8), 64'h0001);
    check("pin8_s7f80", ref_prod(1'b1, 32'h7F, 32'h80, 8), 64'hC080);
`ifndef MULT_EARLY_TERM_EN
    check("pin8_lat", ref_lat(1'b1, 32'h55, 8, 2), 3);
`endif
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 10; bi++) begin
        t8(1'b0, 8'(ai), blist[bi]);
        t8(1'b1, 8'(ai), blist[bi]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
